// File: rtl/sprite_sheet_loader_pkg.sv
// Shared types and constants for the sprite sheet loader.
// Optional build macro: SPRITE_LOADER_CHECKSUM_EN adds the CHECK state
// (trailing 8-bit modulo-sum byte after every payload).
package sprite_loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    SHEET,
    PAL_DATA,
    IMG_DATA,
`ifdef SPRITE_LOADER_CHECKSUM_EN
    CHECK,
`endif
    DONE
  } state_t;

  localparam logic [7:0] SYNC_BYTE   = 8'hA5;
  localparam logic [7:0] CMD_PALETTE = 8'h01;
  localparam logic [7:0] CMD_IMAGE   = 8'h02;

  localparam int PALETTE_DEPTH = 256;

endpackage

// File: rtl/sprite_sheet_loader_if.sv
// Byte-stream handshake bundle feeding the sprite sheet loader.
// A byte transfers on a rising clock edge where valid and ready are both high.
interface sprite_stream_if (input logic clk);

  logic [7:0] byte_data;
  logic       byte_valid;
  logic       byte_ready;

  modport master (output byte_data, output byte_valid, input byte_ready);
  modport slave  (input byte_data, input byte_valid, output byte_ready);

endinterface

// File: rtl/sprite_sheet_loader.sv
// Sprite sheet loader: parses A5-synced frames from a byte stream and writes
// palette entries or sheet pixels straight into the RAM write ports.
// Optional build macro: SPRITE_LOADER_CHECKSUM_EN (trailing checksum byte).
module sprite_sheet_loader
  import sprite_loader_pkg::*;
#(
  parameter  int WIDTH       = 256,
  parameter  int HEIGHT      = 256,
  parameter  int SHEET_COUNT = 2,
  localparam int ADDR_W      = $clog2(SHEET_COUNT * WIDTH * HEIGHT)
) (
  input  logic              pixel_clk_in,
  input  logic              rst_n_in,
  input  logic [7:0]        byte_in,
  input  logic              byte_valid_in,
  output logic              byte_ready_out,
  output logic [ADDR_W-1:0] image_addr_out,
  output logic [7:0]        image_data_out,
  output logic              image_we_out,
  output logic [7:0]        palette_addr_out,
  output logic [23:0]       palette_data_out,
  output logic              palette_we_out,
  output logic              busy_out,
  output logic              done_out,
  output logic              err_out
);

  localparam int PIXELS = WIDTH * HEIGHT;
  // One extra value of headroom keeps the width sane for tiny sprites.
  localparam int OFF_W = $clog2(PIXELS + 1);
  localparam logic [OFF_W-1:0] LAST_OFF = OFF_W'(PIXELS - 1);
  localparam logic [7:0] LAST_PAL = 8'(PALETTE_DEPTH - 1);

  state_t            state;
  logic [OFF_W-1:0]  offset;
  logic [ADDR_W-1:0] sheet_base;
  logic [1:0]        pal_phase;
  logic [7:0]        pal_idx;
  logic [7:0]        red;
  logic [7:0]        green;
`ifdef SPRITE_LOADER_CHECKSUM_EN
  logic [7:0]        sum;
`endif

  logic accept;
  assign accept = byte_valid_in & byte_ready_out;

  // Frame parser FSM; all outputs are registered here, strobes default low.
  always_ff @(posedge pixel_clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state            <= IDLE;
      offset           <= '0;
      sheet_base       <= '0;
      pal_phase        <= '0;
      pal_idx          <= '0;
      red              <= '0;
      green            <= '0;
`ifdef SPRITE_LOADER_CHECKSUM_EN
      sum              <= '0;
`endif
      byte_ready_out   <= 1'b0;
      image_addr_out   <= '0;
      image_data_out   <= '0;
      image_we_out     <= 1'b0;
      palette_addr_out <= '0;
      palette_data_out <= '0;
      palette_we_out   <= 1'b0;
      busy_out         <= 1'b0;
      done_out         <= 1'b0;
      err_out          <= 1'b0;
    end else begin
      image_we_out   <= 1'b0;
      palette_we_out <= 1'b0;
      done_out       <= 1'b0;
      byte_ready_out <= 1'b1;
      case (state)
        IDLE: begin
          if (accept && byte_in == SYNC_BYTE) begin
            state    <= CMD;
            busy_out <= 1'b1;
            err_out  <= 1'b0;
          end
        end
        CMD: begin
          if (accept) begin
`ifdef SPRITE_LOADER_CHECKSUM_EN
            sum <= '0;
`endif
            if (byte_in == CMD_PALETTE) begin
              state     <= PAL_DATA;
              pal_phase <= '0;
              pal_idx   <= '0;
            end else if (byte_in == CMD_IMAGE) begin
              state <= SHEET;
            end else begin
              state    <= IDLE;
              busy_out <= 1'b0;
              err_out  <= 1'b1;
            end
          end
        end
        SHEET: begin
          if (accept) begin
`ifdef SPRITE_LOADER_CHECKSUM_EN
            sum <= sum + byte_in;
`endif
            if (32'(byte_in) < SHEET_COUNT) begin
              state      <= IMG_DATA;
              offset     <= '0;
              sheet_base <= ADDR_W'(32'(byte_in) * PIXELS);
            end else begin
              state    <= IDLE;
              busy_out <= 1'b0;
              err_out  <= 1'b1;
            end
          end
        end
        PAL_DATA: begin
          if (accept) begin
`ifdef SPRITE_LOADER_CHECKSUM_EN
            sum <= sum + byte_in;
`endif
            if (pal_phase == 2'd0) begin
              red       <= byte_in;
              pal_phase <= 2'd1;
            end else if (pal_phase == 2'd1) begin
              green     <= byte_in;
              pal_phase <= 2'd2;
            end else begin
              pal_phase        <= 2'd0;
              palette_addr_out <= pal_idx;
              palette_data_out <= {red, green, byte_in};
              palette_we_out   <= 1'b1;
              pal_idx          <= pal_idx + 8'd1;
              if (pal_idx == LAST_PAL) begin
`ifdef SPRITE_LOADER_CHECKSUM_EN
                state <= CHECK;
`else
                state          <= DONE;
                done_out       <= 1'b1;
                byte_ready_out <= 1'b0;
`endif
              end
            end
          end
        end
        IMG_DATA: begin
          if (accept) begin
`ifdef SPRITE_LOADER_CHECKSUM_EN
            sum <= sum + byte_in;
`endif
            image_addr_out <= sheet_base + ADDR_W'(offset);
            image_data_out <= byte_in;
            image_we_out   <= 1'b1;
            offset         <= offset + 1'b1;
            if (offset == LAST_OFF) begin
`ifdef SPRITE_LOADER_CHECKSUM_EN
              state <= CHECK;
`else
              state          <= DONE;
              done_out       <= 1'b1;
              byte_ready_out <= 1'b0;
`endif
            end
          end
        end
`ifdef SPRITE_LOADER_CHECKSUM_EN
        CHECK: begin
          if (accept) begin
            if (byte_in == sum) begin
              state          <= DONE;
              done_out       <= 1'b1;
              byte_ready_out <= 1'b0;
            end else begin
              state    <= IDLE;
              busy_out <= 1'b0;
              err_out  <= 1'b1;
            end
          end
        end
`endif
        DONE: begin
          state    <= IDLE;
          busy_out <= 1'b0;
        end
        default: begin
          state    <= IDLE;
          busy_out <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/sprite_sheet_loader.md
SPRITE_SHEET_LOADER -- requirements
Module: sprite_sheet_loader

Interface
REQ-001 SHALL have parameter WIDTH, default 256, meaning sprite width in pixels.
REQ-002 SHALL have parameter HEIGHT, default 256, meaning sprite height in pixels.
REQ-003 SHALL have parameter SHEET_COUNT, default 2, meaning number of sprite sheets in image memory.
REQ-004 SHALL have port pixel_clk_in, input, 1 bit: the single clock; one clock, all logic on its rising edge.
REQ-005 SHALL have port rst_n_in, input, 1 bit: reset, asynchronous, active-low.
REQ-006 SHALL have port byte_in, input, 8 bits: stream byte.
REQ-007 SHALL have port byte_valid_in, input, 1 bit: byte_in valid.
REQ-008 SHALL have port byte_ready_out, output, 1 bit: loader accepts byte; transfer occurs when valid and ready are both high.
REQ-009 SHALL have port image_addr_out, output, $clog2(SHEET_COUNT*WIDTH*HEIGHT) bits: image memory write address.
REQ-010 SHALL have port image_data_out, output, 8 bits: color id to write.
REQ-011 SHALL have port image_we_out, output, 1 bit: image write strobe.
REQ-012 SHALL have port palette_addr_out, output, 8 bits: palette write address.
REQ-013 SHALL have port palette_data_out, output, 24 bits: {R,G,B} to write.
REQ-014 SHALL have port palette_we_out, output, 1 bit: palette write strobe.
REQ-015 SHALL have port busy_out, output, 1 bit: high when not in IDLE.
REQ-016 SHALL have port done_out, output, 1 bit: one-cycle pulse when a command completes.
REQ-017 SHALL have port err_out, output, 1 bit: sticky error flag.

Function
REQ-018 SHALL parse frames of the form 0xA5 sync, then command, then payload.
- Command 0x01: payload is 768 bytes, R,G,B per entry, palette index 0..255.
- Command 0x02: payload is a sheet byte followed by WIDTH*HEIGHT color ids in raster order.
REQ-019 SHALL use states IDLE, CMD, SHEET, PAL_DATA, IMG_DATA, CHECK, DONE.
- IDLE to CMD on an accepted 0xA5; any other byte is discarded.
- CMD to PAL_DATA on 0x01, to SHEET on 0x02; any other value sets err_out and returns to IDLE.
- SHEET to IMG_DATA if sheet < SHEET_COUNT; otherwise sets err_out and returns to IDLE.
- PAL_DATA / IMG_DATA to CHECK (macro defined) or DONE (macro undefined) after the last payload byte is accepted.
- DONE to IDLE after exactly 1 cycle.
REQ-020 SHALL write image bytes as follows:
- image_we_out pulses 1 cycle after each accepted IMG_DATA byte.
- image_addr_out = sheet*WIDTH*HEIGHT + offset, with offset counting 0..WIDTH*HEIGHT-1.
- Address arithmetic is done at full address width with no truncation.
REQ-021 SHALL write palette entries as follows:
- palette_we_out pulses 1 cycle after the third byte (B) of each triple is accepted.
- palette_data_out[23:16]=R, [15:8]=G, [7:0]=B.
- palette_addr_out equals the entry index.
REQ-022 SHALL hold byte_ready_out high in every state except DONE, where it is low.
REQ-023 SHALL hold write strobes, address and data outputs stable between strobes and never assert both strobes in the same cycle.
REQ-024 SHALL pulse done_out for the single cycle the FSM is in DONE.
REQ-025 SHALL clear err_out only on the next accepted 0xA5 in IDLE.
REQ-026 SHALL leave state unchanged in any cycle where byte_valid_in is low; stalls of any length are legal.

Reset
REQ-027 SHALL, while rst_n_in is low, drive FSM=IDLE, all counters=0, byte_ready_out=0 and every other output=0, asynchronously.
REQ-028 SHALL take byte_ready_out high on the first clock after reset deassertion.
REQ-029 SHALL abandon a frame that is reset mid-operation with no further writes; memory contents written so far are left as-is.

Configuration
REQ-030 SHALL, with SPRITE_LOADER_CHECKSUM_EN defined:
- Expect one trailing byte equal to the 8-bit modulo sum of all payload bytes, including the sheet byte.
- In CHECK, on match go to DONE.
- On mismatch set err_out, return to IDLE, and do not pulse done_out.
REQ-031 SHALL, without SPRITE_LOADER_CHECKSUM_EN, omit the CHECK state and the sum logic entirely.

Structure
REQ-032 SHALL place the following in package sprite_loader_pkg:
- State enum.
- SYNC_BYTE=8'hA5, CMD_PALETTE=8'h01, CMD_IMAGE=8'h02.
- PALETTE_DEPTH=256.
REQ-033 SHALL be a single module with no sub-modules; write ports connect directly to the write side of the image and palette RAMs.

Verification
REQ-034 SHALL pass: A5 01 then triples (00,00,00),(FF,80,01) and so on -> palette_we_out pulses at addr 0 data 000000, then addr 1 data FF8001; done_out pulses after the 768th byte.
REQ-035 SHALL pass: A5 02 01 then 65536 bytes n mod 256, with defaults -> first write at image_addr 65536 data 00, last write at 131071 data FF; done_out pulses once.
REQ-036 SHALL pass: A5 02 02 -> err_out=1, no write strobes, busy_out=0 next cycle; a following A5 clears err_out.
REQ-037 SHALL pass: A5 07 -> err_out=1, FSM returns to IDLE; a following 55 is ignored.
REQ-038 SHALL pass: rst_n_in pulsed low after 100 image bytes -> all outputs 0 immediately, no further strobes, and a new A5 01 frame loads correctly.
REQ-039 SHALL pass, with SPRITE_LOADER_CHECKSUM_EN: an image frame with a wrong checksum -> err_out=1 and done_out never pulses; the correct checksum -> done_out pulses.
